avbus_fifo_slave: RTL and testbench
===================================

// Module: avbus_fifo_slave
// PURPOSE
// - External-bus slave on the im_avbus port of soc_system (Avalon-to-External-Bus bridge, HPS master side).
// - Consumes HPS bus cycles: small register bank, TX FIFO (HPS->fabric stream), RX FIFO (fabric->HPS stream).
// - Drives acknowledge/read_data/irq back to the bridge and ctrl_export-style control byte to fabric logic.
// PARAMETERS
// - DEPTH_LOG2  4   log2 of each FIFO depth (16 words); legal 1..7.
// - ADDR_W      17  bus address width (byte address); only bits [4:2] decoded, [16:5] ignored (aliases).
// PORTS
// - clk_clk              in   1   system clock
// - reset_reset          in   1   synchronous active-high reset
// - avbus_address        in   17  byte address from bridge
// - avbus_bus_enable     in   1   transfer request, held until acknowledge
// - avbus_byte_enable    in   4   byte lanes (CTRL/IRQ_EN writes only)
// - avbus_rw             in   1   1=read, 0=write
// - avbus_write_data     in   32  write data
// - avbus_read_data      out  32  read data, valid with acknowledge
// - avbus_acknowledge    out  1   one-cycle completion pulse
// - avbus_irq            out  1   level interrupt to bridge
// - ctrl_out             out  8   CTRL[7:0] to fabric
// - tx_data/tx_valid/tx_ready  out/out/in  32/1/1  TX stream, first-word-fall-through
// - rx_data/rx_valid/rx_ready  in/in/out   32/1/1  RX stream into RX FIFO
// BEHAVIOUR
// - Reset: all outputs 0, FSM IDLE, both FIFOs empty, CTRL=0, IRQ_EN=0, overflow flag=0.
// - FSM: IDLE -(bus_enable=1)-> ACCESS -> ACK -> DONE -> IDLE.
//   ACCESS: decode, side effects (push/pop/W1C), latch read_data. ACK: acknowledge=1 one cycle.
//   DONE: bus_enable ignored one cycle (bridge drops it after ack). Latency: enable@0 -> ack@2.
// - read_data holds last read value until next read; writes do not change it.
// - Register map (addr[4:2]):
//   0 CTRL    RW [7:0]->ctrl_out, byte_enable[0] gates write, [31:8] read 0.
//   1 STATUS  RO [0]tx_full [1]tx_empty [2]rx_full [3]rx_empty [15:8]tx_count [23:16]rx_count.
//   2 TX_DATA WO push full word (byte_enable ignored); if full at cycle start -> dropped, OVF=1.
//   3 RX_DATA RO pop head; if empty -> returns 0, no pop.
//   4 IRQ_EN  RW [2:0], byte_enable[0] gates.
//   5 IRQ_STAT [0]!rx_empty (level) [1]tx_empty (level) [2]OVF sticky, write-1-to-clear.
//   6,7 read 0, writes ignored; still acknowledged.
// - avbus_irq registered: |(IRQ_STAT & IRQ_EN), one cycle after cause.
// - TX: tx_valid=!tx_empty, tx_data=head; pop on tx_valid&tx_ready. RX: rx_ready=!rx_full; push on rx_valid&rx_ready.
// - Same-cycle push+pop on one FIFO: both occur, count unchanged; full check uses start-of-cycle state
//   (bus push to full TX FIFO rejected even if stream pops same cycle).
// - Counts width DEPTH_LOG2+1, pointers wrap modulo depth.
// - OVF set and W1C same cycle: set wins.
// - Reset mid-transaction: FSM to IDLE, no acknowledge issued, FIFO contents lost.
// CONFIGURATION
// - AVBUS_LOOPBACK_EN defined: CTRL[7]=1 moves TX head into RX FIFO whenever TX non-empty and RX non-full
//   (one word/cycle); tx_valid and rx_ready forced 0 while active. Bit still drives ctrl_out[7].
// - Not defined: CTRL[7] is plain storage bit, no loopback logic.
// TESTING
// - Reset then read STATUS -> read_data=0x0000_000A, ack exactly 2 cycles after bus_enable, irq=0.
// - Write CTRL=0x1234_56A5 byte_enable=4'b0001 -> ctrl_out=0xA5, read CTRL=0x0000_00A5.
// - Push 17 words to TX_DATA, tx_ready=0 -> STATUS tx_count=16, tx_full=1, IRQ_STAT[2]=1; W1C 0x4 clears it.
// - Fabric pushes 0xCAFEF00D, IRQ_EN=1 -> irq=1; read RX_DATA -> 0xCAFEF00D, irq=0; read again -> 0.
// - TX full, bus write and tx_ready=1 same cycle -> one pop, write dropped, tx_count=15, OVF=1.
// - AVBUS_LOOPBACK_EN, CTRL=0x80, push 0x1,0x2 -> RX_DATA reads 0x1 then 0x2, tx_valid stays 0.

Source files
------------

// File: rtl/avbus_fifo_slave.sv
// rtl/avbus_fifo_slave.sv - external-bus register slave with TX/RX word FIFOs
//
// Purpose:
//   This block is a slave on the bridge's external-bus port. It serves a small register bank,
//   a TX FIFO that carries words from the HPS to the fabric, and an RX FIFO that carries words
//   from the fabric to the HPS. It returns acknowledge, read data and a level interrupt.
//
// Optional feature macro: AVBUS_LOOPBACK_EN
//   When this macro is defined, CTRL[7] moves the TX head into the RX FIFO at one word per cycle.
//   While loopback is active, tx_valid and rx_ready are held low.
//   When the macro is undefined, CTRL[7] is only a storage bit.
//
// Ports:
//   clk_clk, reset_reset           clock and synchronous active-high reset
//   avbus_address[ADDR_W-1:0]      byte address; only bits [4:2] select a register
//   avbus_bus_enable               request, held by the bridge until acknowledge
//   avbus_byte_enable[3:0]         lane 0 gates CTRL and IRQ_EN writes
//   avbus_rw                       1 = read, 0 = write
//   avbus_write_data[31:0]         write data
//   avbus_read_data[31:0]          last read value, valid with acknowledge
//   avbus_acknowledge              one-cycle completion pulse
//   avbus_irq                      registered level interrupt
//   ctrl_out[7:0]                  CTRL register to fabric
//   tx_data/tx_valid/tx_ready      TX stream out, first-word-fall-through
//   rx_data/rx_valid/rx_ready      RX stream into the RX FIFO

module avbus_fifo_slave_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int W          = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [W-1:0]          push_data,
  input  logic                  pop,
  output logic [W-1:0]          head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  logic [W-1:0]            mem_q [DEPTH];
  logic [W-1:0]            mem_d [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    push_ok, pop_ok;

  // Full and empty are based on the state at the start of the cycle.
  // As a result, a push to a full FIFO is rejected even when a pop happens in the same cycle.
  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + DEPTH_LOG2'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

module avbus_fifo_slave #(
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_W     = 17
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic [ADDR_W-1:0] avbus_address,
  input  logic              avbus_bus_enable,
  input  logic [3:0]        avbus_byte_enable,
  input  logic              avbus_rw,
  input  logic [31:0]       avbus_write_data,
  output logic [31:0]       avbus_read_data,
  output logic              avbus_acknowledge,
  output logic              avbus_irq,
  output logic [7:0]        ctrl_out,
  output logic [31:0]       tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [31:0]       rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACK, S_DONE} state_t;

  localparam logic [2:0] R_CTRL     = 3'd0;
  localparam logic [2:0] R_STATUS   = 3'd1;
  localparam logic [2:0] R_TX_DATA  = 3'd2;
  localparam logic [2:0] R_RX_DATA  = 3'd3;
  localparam logic [2:0] R_IRQ_EN   = 3'd4;
  localparam logic [2:0] R_IRQ_STAT = 3'd5;

  state_t        state_q, state_d;
  logic          ack_q, ack_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;
  logic [7:0]    ctrl_q, ctrl_d;
  logic [2:0]    irq_en_q, irq_en_d;
  logic          ovf_q, ovf_d;

  logic          ovf_set, ovf_clr;
  logic          bus_tx_push, bus_rx_pop;
  logic [2:0]    reg_sel;
  logic [2:0]    irq_stat;

  logic [31:0]   tx_head, rx_head;
  logic [DEPTH_LOG2:0] tx_count, rx_count;
  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic          tx_pop, rx_push;
  logic [31:0]   rx_push_data;
  logic          lb_active, lb_move;
  logic          unused_ok;

  // Higher address bits alias the 8-register window; byte lanes above 0 never matter.
  assign reg_sel   = avbus_address[4:2];
  assign unused_ok = ^{avbus_address[ADDR_W-1:5], avbus_address[1:0], avbus_byte_enable[3:1]};

`ifdef AVBUS_LOOPBACK_EN
  assign lb_active = ctrl_q[7];
  assign lb_move   = lb_active && !tx_empty && !rx_full;
`else
  assign lb_active = 1'b0;
  assign lb_move   = 1'b0;
`endif

  // The fabric-side handshakes are blocked while loopback owns both FIFOs.
  // rx_ready is also held low while reset is asserted.
  assign tx_valid     = !lb_active && !tx_empty;
  assign tx_data      = tx_head;
  assign rx_ready     = !reset_reset && !lb_active && !rx_full;
  assign tx_pop       = (tx_valid && tx_ready) || lb_move;
  assign rx_push      = (rx_valid && rx_ready) || lb_move;
  assign rx_push_data = lb_move ? tx_head : rx_data;

  avbus_fifo_slave_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(32)) u_tx_fifo (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .push      (bus_tx_push),
    .push_data (avbus_write_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  avbus_fifo_slave_fifo #(.DEPTH_LOG2(DEPTH_LOG2), .W(32)) u_rx_fifo (
    .clk       (clk_clk),
    .rst       (reset_reset),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (bus_rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign irq_stat = {ovf_q, tx_empty, !rx_empty};

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    rdata_d     = rdata_q;
    ctrl_d      = ctrl_q;
    irq_en_d    = irq_en_q;
    ovf_set     = 1'b0;
    ovf_clr     = 1'b0;
    bus_tx_push = 1'b0;
    bus_rx_pop  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (avbus_bus_enable) begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // All side effects happen at the edge that ends this state.
        // The acknowledge pulse then appears in S_ACK.
        state_d = S_ACK;
        ack_d   = 1'b1;
        if (avbus_rw) begin
          case (reg_sel)
            R_CTRL:     rdata_d = {24'h0, ctrl_q};
            R_STATUS:   rdata_d = {8'h0, 8'(rx_count), 8'(tx_count),
                                   4'h0, rx_empty, rx_full, tx_empty, tx_full};
            R_RX_DATA: begin
              if (!rx_empty) begin
                rdata_d    = rx_head;
                bus_rx_pop = 1'b1;
              end else begin
                rdata_d = 32'h0;
              end
            end
            R_IRQ_EN:   rdata_d = {29'h0, irq_en_q};
            R_IRQ_STAT: rdata_d = {29'h0, irq_stat};
            default:    rdata_d = 32'h0;
          endcase
        end else begin
          case (reg_sel)
            R_CTRL: begin
              if (avbus_byte_enable[0]) ctrl_d = avbus_write_data[7:0];
            end
            R_TX_DATA: begin
              if (tx_full) ovf_set = 1'b1;
              else         bus_tx_push = 1'b1;
            end
            R_IRQ_EN: begin
              if (avbus_byte_enable[0]) irq_en_d = avbus_write_data[2:0];
            end
            R_IRQ_STAT: begin
              if (avbus_write_data[2]) ovf_clr = 1'b1;
            end
            default: ;
          endcase
        end
      end
      S_ACK:   state_d = S_DONE;
      // The bridge is still dropping bus_enable in this cycle, so the request is ignored here.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // If the overflow flag is set and cleared in the same cycle, the set takes priority.
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;

    irq_d = |(irq_stat & irq_en_q);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      rdata_q  <= 32'h0;
      irq_q    <= 1'b0;
      ctrl_q   <= 8'h0;
      irq_en_q <= 3'h0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      ctrl_q   <= ctrl_d;
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
    end
  end

  assign avbus_acknowledge = ack_q;
  assign avbus_read_data   = rdata_q;
  assign avbus_irq         = irq_q;
  assign ctrl_out          = ctrl_q;
endmodule

// File: tb/tb_avbus_fifo_slave.sv
// tb/tb_avbus_fifo_slave.sv - self-checking bench for avbus_fifo_slave

module tb_avbus_fifo_slave;
  logic        clk = 1'b0;
  logic        reset_reset;
  logic [16:0] avbus_address;
  logic        avbus_bus_enable;
  logic [3:0]  avbus_byte_enable;
  logic        avbus_rw;
  logic [31:0] avbus_write_data;
  logic [31:0] avbus_read_data;
  logic        avbus_acknowledge;
  logic        avbus_irq;
  logic [7:0]  ctrl_out;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  logic [31:0] tx_sb[$];
  logic [31:0] rx_sb[$];

  localparam logic [16:0] A_CTRL   = 17'h00;
  localparam logic [16:0] A_STATUS = 17'h04;
  localparam logic [16:0] A_TX     = 17'h08;
  localparam logic [16:0] A_RX     = 17'h0C;
  localparam logic [16:0] A_IEN    = 17'h10;
  localparam logic [16:0] A_IST    = 17'h14;
  localparam logic [16:0] A_R6     = 17'h18;
  localparam logic [16:0] A_R7     = 17'h1C;

  always #5 clk = ~clk;

  avbus_fifo_slave dut (
    .clk_clk           (clk),
    .reset_reset       (reset_reset),
    .avbus_address     (avbus_address),
    .avbus_bus_enable  (avbus_bus_enable),
    .avbus_byte_enable (avbus_byte_enable),
    .avbus_rw          (avbus_rw),
    .avbus_write_data  (avbus_write_data),
    .avbus_read_data   (avbus_read_data),
    .avbus_acknowledge (avbus_acknowledge),
    .avbus_irq         (avbus_irq),
    .ctrl_out          (ctrl_out),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .rx_data           (rx_data),
    .rx_valid          (rx_valid),
    .rx_ready          (rx_ready)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // One bus cycle. Latency is counted in clock edges from bus_enable to the sampled acknowledge.
  task automatic bus(input logic rw, input logic [16:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input logic pop_tx,
                     output logic [31:0] rd, output int lat, output logic ack_after);
    logic got;
    @(negedge clk);
    avbus_rw          = rw;
    avbus_address     = addr;
    avbus_write_data  = wd;
    avbus_byte_enable = be;
    avbus_bus_enable  = 1'b1;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1 && pop_tx) tx_ready = 1'b1;
      if (avbus_acknowledge) got = 1'b1;
    end
    rd = avbus_read_data;
    avbus_bus_enable = 1'b0;
    if (pop_tx) tx_ready = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL bus_timeout: addr %h got no acknowledge, required one within 20 cycles", addr);
    end
    @(negedge clk);
    ack_after = avbus_acknowledge;
  endtask

  task automatic wr(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [31:0] r;
    int l;
    logic aa;
    bus(1'b0, a, d, be, 1'b0, r, l, aa);
  endtask

  task automatic rd(input logic [16:0] a, output logic [31:0] d);
    int l;
    logic aa;
    bus(1'b1, a, 32'h0, 4'h0, 1'b0, d, l, aa);
  endtask

  task automatic test_reset;
    logic [31:0] r, e;
    int l;
    logic aa;
    reset_reset = 1'b1;
    avbus_bus_enable = 1'b0; avbus_rw = 1'b0; avbus_address = '0;
    avbus_write_data = '0; avbus_byte_enable = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({avbus_acknowledge, avbus_irq, avbus_read_data, ctrl_out, tx_valid, tx_data, rx_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: ack=%b irq=%b rd=%h ctrl=%h txv=%b txd=%h rxr=%b, required all 0",
               avbus_acknowledge, avbus_irq, avbus_read_data, ctrl_out, tx_valid, tx_data, rx_ready);
    end
    reset_reset = 1'b0;
    exp_q.push_back(32'h0000_000A);
    bus(1'b1, A_STATUS, 32'h0, 4'h0, 1'b0, r, l, aa);
    e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL reset_status: got %h required %h", r, e); end
    tests++; if (l !== 2) begin fails++; $display("FAIL ack_latency: got %0d required 2", l); end
    tests++; if (aa !== 1'b0) begin fails++; $display("FAIL ack_one_cycle: got %b required 0", aa); end
    tests++; if (avbus_irq !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b required 0", avbus_irq); end
  endtask

  task automatic test_ctrl;
    logic [31:0] r, e;
    wr(A_CTRL, 32'h1234_56A5, 4'b0001);
    tests++; if (ctrl_out !== 8'hA5) begin fails++; $display("FAIL ctrl_out: got %h required a5", ctrl_out); end
    exp_q.push_back(32'h0000_00A5);
    rd(A_CTRL, r);
    e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL ctrl_read: got %h required %h", r, e); end
    wr(A_CTRL, 32'h0000_00FF, 4'b1110);
    tests++; if (ctrl_out !== 8'hA5) begin fails++; $display("FAIL ctrl_be_gate: got %h required a5", ctrl_out); end
    tests++; if (avbus_read_data !== 32'h0000_00A5) begin
      fails++; $display("FAIL read_data_hold: got %h required 000000a5", avbus_read_data);
    end
    wr(A_CTRL, 32'h0, 4'b0001);
  endtask

  task automatic test_tx_overflow;
    logic [31:0] r, e, w;
    tx_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      w = 32'h1000_0000 + i;
      if (i < 16) tx_sb.push_back(w);
      wr(A_TX, w, 4'h0);
    end
    exp_q.push_back(32'h0000_1009);
    rd(A_STATUS, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL tx_full_status: got %h required %h", r, e); end
    exp_q.push_back(32'h0000_0004);
    rd(A_IST, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL ovf_set: got %h required %h", r, e); end
    wr(A_IST, 32'h4, 4'h0);
    exp_q.push_back(32'h0000_0000);
    rd(A_IST, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL ovf_w1c: got %h required %h", r, e); end
  endtask

  task automatic test_full_push_pop;
    logic [31:0] r, e;
    int l;
    logic aa;
    e = tx_sb.pop_front();
    tests++; if (tx_data !== e || tx_valid !== 1'b1) begin
      fails++; $display("FAIL tx_head_full: got %h valid %b required %h valid 1", tx_data, tx_valid, e);
    end
    bus(1'b0, A_TX, 32'hDEAD_BEEF, 4'h0, 1'b1, r, l, aa);
    exp_q.push_back(32'h0000_0F08);
    rd(A_STATUS, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL full_push_pop_status: got %h required %h", r, e); end
    exp_q.push_back(32'h0000_0004);
    rd(A_IST, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL full_push_pop_ovf: got %h required %h", r, e); end
    wr(A_IST, 32'h4, 4'h0);
    for (int c = 0; c < 40 && tx_valid; c++) begin
      tests++;
      if (tx_sb.size() == 0) begin
        fails++; $display("FAIL tx_extra_word: got %h required no word", tx_data);
      end else begin
        e = tx_sb.pop_front();
        if (tx_data !== e) begin fails++; $display("FAIL tx_stream: got %h required %h", tx_data, e); end
      end
      tx_ready = 1'b1;
      @(negedge clk);
    end
    tx_ready = 1'b0;
    tests++; if (tx_sb.size() != 0) begin
      fails++; $display("FAIL tx_drain: got %0d words left required 0", tx_sb.size());
    end
    exp_q.push_back(32'h0000_000A);
    rd(A_STATUS, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL tx_drained_status: got %h required %h", r, e); end
  endtask

  task automatic test_rx_irq;
    logic [31:0] r, e;
    @(negedge clk);
    rx_data = 32'hCAFE_F00D; rx_valid = 1'b1;
    if (rx_ready) rx_sb.push_back(rx_data);
    @(negedge clk);
    rx_valid = 1'b0;
    wr(A_IEN, 32'h1, 4'b0001);
    tests++; if (avbus_irq !== 1'b1) begin fails++; $display("FAIL irq_rx_set: got %b required 1", avbus_irq); end
    e = (rx_sb.size() != 0) ? rx_sb.pop_front() : 32'hCAFE_F00D;
    rd(A_RX, r);
    tests++; if (r !== e) begin fails++; $display("FAIL rx_read: got %h required %h", r, e); end
    tests++; if (avbus_irq !== 1'b0) begin fails++; $display("FAIL irq_rx_clear: got %b required 0", avbus_irq); end
    exp_q.push_back(32'h0);
    rd(A_RX, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL rx_empty_read: got %h required %h", r, e); end
    wr(A_IEN, 32'h2, 4'b0001);
    tests++; if (avbus_irq !== 1'b1) begin fails++; $display("FAIL irq_tx_empty: got %b required 1", avbus_irq); end
    wr(A_IEN, 32'h0, 4'b0001);
    tests++; if (avbus_irq !== 1'b0) begin fails++; $display("FAIL irq_disable: got %b required 0", avbus_irq); end
  endtask

  task automatic test_rx_full;
    logic [31:0] r, e;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = 32'h2000_0000 + i;
      if (rx_ready) rx_sb.push_back(rx_data);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    tests++; if (rx_ready !== 1'b0) begin fails++; $display("FAIL rx_ready_full: got %b required 0", rx_ready); end
    tests++; if (rx_sb.size() != 16) begin
      fails++; $display("FAIL rx_accepted: got %0d words required 16", rx_sb.size());
    end
    exp_q.push_back(32'h0010_0006);
    rd(A_STATUS, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL rx_full_status: got %h required %h", r, e); end
    while (rx_sb.size() != 0) begin
      e = rx_sb.pop_front();
      rd(A_RX, r);
      tests++; if (r !== e) begin fails++; $display("FAIL rx_order: got %h required %h", r, e); end
    end
  endtask

  task automatic test_aliases;
    logic [31:0] r, e;
    int l;
    logic aa;
    exp_q.push_back(32'h0);
    rd(A_R6, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL reg6_read: got %h required %h", r, e); end
    bus(1'b0, A_R7, 32'hFFFF_FFFF, 4'hF, 1'b0, r, l, aa);
    tests++; if (l !== 2) begin fails++; $display("FAIL reg7_ack: got latency %0d required 2", l); end
    wr(17'h1_FFE0, 32'h11, 4'b0001);
    tests++; if (ctrl_out !== 8'h11) begin fails++; $display("FAIL alias_write: got %h required 11", ctrl_out); end
    exp_q.push_back(32'h11);
    rd(17'h0_0020, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL alias_read: got %h required %h", r, e); end
    wr(A_CTRL, 32'h0, 4'b0001);
  endtask

  task automatic test_reset_mid;
    logic [31:0] r, e;
    logic seen;
    @(negedge clk);
    avbus_rw = 1'b0; avbus_address = A_TX; avbus_write_data = 32'h5555_AAAA;
    avbus_byte_enable = 4'hF; avbus_bus_enable = 1'b1;
    @(negedge clk);
    reset_reset = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (avbus_acknowledge) seen = 1'b1;
      avbus_bus_enable = 1'b0;
      reset_reset = 1'b0;
    end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL reset_mid_ack: got %b required 0", seen); end
    exp_q.push_back(32'h0000_000A);
    rd(A_STATUS, r); e = exp_q.pop_front();
    tests++; if (r !== e) begin fails++; $display("FAIL reset_mid_status: got %h required %h", r, e); end
  endtask

  task automatic test_ctrl7;
    logic [31:0] r, e;
    wr(A_CTRL, 32'h80, 4'b0001);
    tests++; if (ctrl_out !== 8'h80) begin fails++; $display("FAIL ctrl7_out: got %h required 80", ctrl_out); end
`ifdef AVBUS_LOOPBACK_EN
    wr(A_TX, 32'h1, 4'h0);
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL lb_txvalid1: got %b required 0", tx_valid); end
    wr(A_TX, 32'h2, 4'h0);
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL lb_txvalid2: got %b required 0", tx_valid); end
    exp_q.push_back(32'h1);
    exp_q.push_back(32'h2);
    for (int i = 0; i < 2; i++) begin
      rd(A_RX, r); e = exp_q.pop_front();
      tests++; if (r !== e) begin fails++; $display("FAIL lb_rx: got %h required %h", r, e); end
    end
`else
    wr(A_TX, 32'h1, 4'h0);
    tests++; if (tx_valid !== 1'b1 || tx_data !== 32'h1) begin
      fails++; $display("FAIL ctrl7_plain: got valid %b data %h required valid 1 data 1", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    tests++; if (tx_valid !== 1'b0) begin fails++; $display("FAIL ctrl7_pop: got %b required 0", tx_valid); end
`endif
    wr(A_CTRL, 32'h0, 4'b0001);
  endtask

  initial begin
    test_reset();
    test_ctrl();
    test_tx_overflow();
    test_full_push_pop();
    test_rx_irq();
    test_rx_full();
    test_aliases();
    test_reset_mid();
    test_ctrl7();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
